// File: rtl/sat_acc_pkg.sv
// Shared types and helpers for the saturating burst accumulator.
// Holds the sequencer state encoding and signed range limits.
package sat_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/sat_add_w.sv
// Combinational W-bit signed adder that clamps to the signed range.
// ovf_o flags that the true sum did not fit and was clamped.
module sat_add_w
   import sat_acc_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   localparam logic [W-1:0] MAXV = W'(sat_max(W));
   localparam logic [W-1:0] MINV = W'(sat_min(W));

   logic [W:0] wide;

   always_comb begin
      wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
      // Top two bits disagree exactly when same-sign inputs flip sign.
      ovf_o = wide[W] ^ wide[W-1];
      if (!ovf_o) begin
         sum_o = wide[W-1:0];
      end else if (wide[W]) begin
         sum_o = MINV;
      end else begin
         sum_o = MAXV;
      end
   end

endmodule

// File: rtl/sat_accumulator.sv
// Burst sequencer feeding one saturating adder, one operand per beat.
// Returns the clamped sum and a sticky saturation flag on a result port.
module sat_accumulator
   import sat_acc_pkg::*;
#(
   parameter  int W       = 4,
   parameter  int MAX_LEN = 8,
   localparam int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] len,
   output logic          busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_sum,
   output logic          out_sat
);

   localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_e        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic          sat_q, sat_d;
   logic [CW-1:0] rem_q, rem_d;

   logic [W-1:0]  add_sum;
   logic          add_ovf;
   logic [CW-1:0] len_clamp;
   logic          beat;
   logic          take_start;

   sat_add_w #(.W(W)) u_add (
      .a_i   (acc_q),
      .b_i   (in_data),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   assign len_clamp  = (len > LEN_MAX) ? LEN_MAX : len;
   assign beat       = (state_q == ACCUM) && in_valid;
   assign take_start = (state_q == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid && rem_q == ONE) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: ;
         ACCUM: begin
            busy     = 1'b1;
            in_ready = 1'b1;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      rem_d = rem_q;
      if (take_start) begin
         acc_d = '0;
         sat_d = 1'b0;
         rem_d = len_clamp;
      end else if (beat) begin
         acc_d = add_sum;
         sat_d = sat_q | add_ovf;
         rem_d = rem_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         rem_q <= '0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
         rem_q <= rem_d;
      end
   end

   // Result comes straight from flops: no path from in_data.
   assign out_sum = acc_q;
   assign out_sat = sat_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator: bursts, clamps, stalls, edges.
// Expected results are queued at burst start and popped on handshake.
module tb_sat_accumulator;

   localparam int W       = 4;
   localparam int MAX_LEN = 8;
   localparam int CW      = $clog2(MAX_LEN + 1);

   typedef struct {
      int sum;
      int sat;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] len;
   logic          busy;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_sat;

   int   checks;
   int   errors;
   int   vals[8];
   exp_t sbq[$];

   sat_accumulator #(.W(W), .MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ssum();
      return int'($signed(out_sum));
   endfunction

   // Called and returns at a negedge; vals[] holds the operands.
   task automatic burst(input int l, input int gap, input int ordly,
                        input bit poke);
      int   nb;
      int   acc;
      int   s;
      int   t;
      bit   got;
      exp_t e;
      nb  = (l > MAX_LEN) ? MAX_LEN : l;
      acc = 0;
      s   = 0;
      for (int i = 0; i < nb; i++) begin
         t = acc + vals[i];
         if (t > 7) begin
            t = 7;
            s = 1;
         end else if (t < -8) begin
            t = -8;
            s = 1;
         end
         acc = t;
      end
      e.sum = acc;
      e.sat = s;
      sbq.push_back(e);
      start = 1'b1;
      len   = CW'(l);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < nb; i++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 4'h7;
            if (poke) begin
               start = 1'b1;
               len   = CW'(0);
            end
            @(negedge clk);
            start = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = W'(vals[i]);
         chk("rdy", int'(in_ready), 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("lat_valid", int'(out_valid), 1);
      chk("rdy_drop", int'(in_ready), 0);
      for (int d = 0; d < ordly; d++) begin
         if (poke) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_sum", ssum(), sbq[0].sum);
      end
      out_ready = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (out_valid) begin
            got = 1'b1;
            e = sbq.pop_front();
            chk("sum", ssum(), e.sum);
            chk("sat", int'(out_sat), e.sat);
         end
         @(negedge clk);
      end
      if (!got) begin
         chk("timeout", 0, 1);
         void'(sbq.pop_front());
      end
      out_ready = 1'b0;
      chk("idle_busy", int'(busy), 0);
      chk("idle_valid", int'(out_valid), 0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rdy", int'(in_ready), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sum", ssum(), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Abort mid-burst with asynchronous reset.
      start = 1'b1;
      len   = CW'(4);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = W'(3);
      @(negedge clk);
      in_data  = W'(2);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_sum", ssum(), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy", int'(busy), 0);
      chk("ar_rdy", int'(in_ready), 0);
      chk("ar_valid", int'(out_valid), 0);
      chk("ar_sum", ssum(), 0);
      chk("ar_sat", int'(out_sat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rdy", int'(in_ready), 0);
      chk("post_busy", int'(busy), 0);

      vals = '{1, 2, -1, 0, 0, 0, 0, 0};
      burst(3, 0, 0, 1'b0);
      vals = '{7, 7, -8, 0, 0, 0, 0, 0};
      burst(3, 0, 0, 1'b0);
      vals = '{-4, -7, 0, 0, 0, 0, 0, 0};
      burst(2, 0, 0, 1'b0);
      vals = '{3, 5, 0, 0, 0, 0, 0, 0};
      burst(2, 3, 4, 1'b1);
      burst(0, 0, 0, 1'b0);
      vals = '{1, -1, 2, -2, 3, -3, 1, 1};
      burst(15, 0, 0, 1'b0);
      vals = '{7, 1, 0, 0, 0, 0, 0, 0};
      burst(2, 0, 0, 1'b0);
      vals = '{2, 3, 0, 0, 0, 0, 0, 0};
      burst(2, 0, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 8; j++) vals[j] = int'($urandom_range(15)) - 8;
         burst(int'($urandom_range(MAX_LEN)), k % 2, k % 3, 1'b0);
      end

      chk("sb_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
